// File: rtl/input_bridge_pkg.sv
`default_nettype none
// ============================================================================
// Module   : input_bridge_pkg
// Brief    : Shared constants for the multi-player paddle input bridge.
// Revision : 1.0 - initial release
// ============================================================================
package input_bridge_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam logic [7:0] CASE_BIT  = 8'h20;

  // Uppercase press keys, indexed by player: W/S, I/K, T/G, P/L
  localparam logic [3:0][7:0] KEY_UP = {8'h50, 8'h54, 8'h49, 8'h57};
  localparam logic [3:0][7:0] KEY_DN = {8'h4C, 8'h47, 8'h4B, 8'h53};

  localparam logic [1:0] MODE_BTN   = 2'd0;
  localparam logic [1:0] MODE_KBD   = 2'd1;
  localparam logic [1:0] MODE_CTRL  = 2'd2;
  localparam logic [1:0] MODE_MERGE = 2'd3;

  localparam logic [1:0] PS_IDLE  = 2'd0;
  localparam logic [1:0] PS_SYNC  = 2'd1;
  localparam logic [1:0] PS_ID    = 2'd2;
  localparam logic [1:0] PS_STATE = 2'd3;

  function automatic logic [7:0] release_key(input logic [7:0] press);
    return press | CASE_BIT;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ctrl_frame_parser.sv
`default_nettype none
// ============================================================================
// Module   : ctrl_frame_parser
// Brief    : 4-byte controller frame FSM with inter-byte gap timeout and checksum.
// Revision : 1.0 - initial release
// ============================================================================
module ctrl_frame_parser
  import input_bridge_pkg::*;
#(
  parameter int PLAYERS    = 2,
  parameter int GAP_CYCLES = 5_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       byte_valid,
  input  logic [7:0] byte_data,
  output logic       busy,
  output logic       frame_ok,
  output logic [1:0] frame_id,
  output logic [1:0] frame_state,
  output logic       frame_err
);

  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] c_gap_last = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [7:0] c_players = 8'(PLAYERS);

  logic [1:0]       r_state;
  logic [GAP_W-1:0] r_gap;
  logic [7:0]       r_id;
  logic [7:0]       r_data;
  logic             r_frame_err;
  logic             w_last;
  logic             w_good;

  assign w_last      = byte_valid && (r_state == PS_STATE);
  assign w_good      = (r_id < c_players) && (byte_data == (r_id ^ r_data));
  assign busy        = (r_state != PS_IDLE);
  assign frame_ok    = w_last && w_good;
  assign frame_id    = r_id[1:0];
  assign frame_state = r_data[1:0];
  assign frame_err   = r_frame_err;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_state     <= PS_IDLE;
      r_gap       <= '0;
      r_id        <= '0;
      r_data      <= '0;
      r_frame_err <= 1'b0;
    end else begin
      r_frame_err <= w_last && !w_good;
      if (byte_valid) begin
        r_gap <= '0;
        case (r_state)
          PS_IDLE:  if (byte_data == SYNC_BYTE) r_state <= PS_SYNC;
          PS_SYNC:  begin r_id   <= byte_data; r_state <= PS_ID;    end
          PS_ID:    begin r_data <= byte_data; r_state <= PS_STATE; end
          default:  r_state <= PS_IDLE;
        endcase
      end else if (r_state != PS_IDLE) begin
        // A stalled frame is abandoned silently once the gap budget is spent
        if (r_gap == c_gap_last) begin
          r_state <= PS_IDLE;
          r_gap   <= '0;
        end else begin
          r_gap <= r_gap + 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/input_bridge_mp.sv
`default_nettype none
// ============================================================================
// Module   : input_bridge_mp
// Brief    : Multi-player paddle input bridge: buttons, keyboard, controller frames.
// Revision : 1.0 - initial release
// ============================================================================
module input_bridge_mp
  import input_bridge_pkg::*;
#(
  parameter int PLAYERS        = 2,
  parameter int TIMEOUT_CYCLES = 25_000_000,
  parameter int GAP_CYCLES     = 5_000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           input_mode,
  input  logic [2*PLAYERS-1:0] btn_clean,
  input  logic                 rx_valid,
  input  logic [7:0]           rx_data,
  output logic [PLAYERS-1:0]   up,
  output logic [PLAYERS-1:0]   down,
  output logic                 frame_err
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] c_cnt_max  = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam bit               c_tmo_en   = (TIMEOUT_CYCLES > 0);

  logic [1:0]         r_mode_prev;
  logic               w_mode_chg;
  logic               w_parser_byte;
  logic               w_kbd_byte;
  logic               w_busy;
  logic               w_frame_ok;
  logic [1:0]         w_frame_id;
  logic [1:0]         w_frame_state;
  logic [PLAYERS-1:0] w_sel_up;
  logic [PLAYERS-1:0] w_sel_dn;

  assign w_mode_chg    = (input_mode != r_mode_prev);
  assign w_parser_byte = rx_valid && !w_mode_chg &&
                         ((input_mode == MODE_CTRL) || (input_mode == MODE_MERGE));
  // In merged mode an open frame owns the byte stream
  assign w_kbd_byte    = rx_valid && !w_mode_chg &&
                         ((input_mode == MODE_KBD) || ((input_mode == MODE_MERGE) && !w_busy));

  always_ff @(posedge clk) begin
    r_mode_prev <= input_mode;
  end

  ctrl_frame_parser #(
    .PLAYERS    (PLAYERS),
    .GAP_CYCLES (GAP_CYCLES)
  ) u_parser (
    .clk         (clk),
    .rst         (rst),
    .clear       (w_mode_chg),
    .byte_valid  (w_parser_byte),
    .byte_data   (rx_data),
    .busy        (w_busy),
    .frame_ok    (w_frame_ok),
    .frame_id    (w_frame_id),
    .frame_state (w_frame_state),
    .frame_err   (frame_err)
  );

  for (genvar p = 0; p < PLAYERS; p++) begin : g_player
    logic             r_u_up;
    logic             r_u_dn;
    logic [CNT_W-1:0] r_cnt;
    logic             w_frame_hit;
    logic             w_up_set, w_up_clr, w_dn_set, w_dn_clr;
    logic             w_refresh;
    logic             w_btn_up, w_btn_dn;

    assign w_frame_hit = w_frame_ok && (w_frame_id == 2'(p));
    assign w_up_set    = w_kbd_byte && (rx_data == KEY_UP[p]);
    assign w_up_clr    = w_kbd_byte && (rx_data == release_key(KEY_UP[p]));
    assign w_dn_set    = w_kbd_byte && (rx_data == KEY_DN[p]);
    assign w_dn_clr    = w_kbd_byte && (rx_data == release_key(KEY_DN[p]));
    assign w_refresh   = w_frame_hit || w_up_set || w_up_clr || w_dn_set || w_dn_clr;

    always_ff @(posedge clk) begin
      if (rst || w_mode_chg) begin
        r_u_up <= 1'b0;
        r_u_dn <= 1'b0;
        r_cnt  <= '0;
      end else if (w_refresh) begin
        r_cnt <= '0;
        if (w_frame_hit) begin
          r_u_up <= w_frame_state[0];
          r_u_dn <= w_frame_state[1];
        end else begin
          if (w_up_set) r_u_up <= 1'b1;
          if (w_up_clr) r_u_up <= 1'b0;
          if (w_dn_set) r_u_dn <= 1'b1;
          if (w_dn_clr) r_u_dn <= 1'b0;
        end
      end else if (c_tmo_en && (r_cnt != c_cnt_max)) begin
        r_cnt <= r_cnt + 1'b1;
        if (r_cnt == c_cnt_last) begin
          r_u_up <= 1'b0;
          r_u_dn <= 1'b0;
        end
      end
    end

    assign w_btn_up    = ~btn_clean[2*p];
    assign w_btn_dn    = ~btn_clean[2*p+1];
    assign w_sel_up[p] = (input_mode == MODE_BTN)   ? w_btn_up :
                         (input_mode == MODE_MERGE) ? (w_btn_up | r_u_up) : r_u_up;
    assign w_sel_dn[p] = (input_mode == MODE_BTN)   ? w_btn_dn :
                         (input_mode == MODE_MERGE) ? (w_btn_dn | r_u_dn) : r_u_dn;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      up   <= '0;
      down <= '0;
    end else begin
      up   <= w_sel_up & ~w_sel_dn;
      down <= w_sel_dn & ~w_sel_up;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_input_bridge_mp.sv
`default_nettype none
// ============================================================================
// Module   : tb_input_bridge_mp
// Brief    : Self-checking bench for input_bridge_mp against a queue/timestamp model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_input_bridge_mp;

  localparam int PLAYERS        = 2;
  localparam int TIMEOUT_CYCLES = 100;
  localparam int GAP_CYCLES     = 20;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] input_mode;
  logic [3:0] btn_clean;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic [1:0] up;
  logic [1:0] down;
  logic       frame_err;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  input_bridge_mp #(
    .PLAYERS        (PLAYERS),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .GAP_CYCLES     (GAP_CYCLES)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .input_mode (input_mode),
    .btn_clean  (btn_clean),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .up         (up),
    .down       (down),
    .frame_err  (frame_err)
  );

  // Reference model state
  bit [1:0] m_u_up, m_u_dn, exp_up, exp_dn;
  bit       exp_err;
  bit [7:0] fq[$];
  int       cyc = 0;
  int       last_byte = 0;
  int       last_ref[PLAYERS];
  bit [1:0] prev_mode;
  bit [7:0] key_up_tab[4] = '{8'h57, 8'h49, 8'h54, 8'h50};
  bit [7:0] key_dn_tab[4] = '{8'h53, 8'h4B, 8'h47, 8'h4C};
  bit [7:0] key_pool[14]  = '{8'h57, 8'h77, 8'h53, 8'h73, 8'h49, 8'h69, 8'h4B,
                              8'h6B, 8'h54, 8'h47, 8'h50, 8'h4C, 8'h41, 8'hA5};

  bit       cur_rst;
  bit [1:0] cur_mode;
  bit [3:0] cur_btn;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h cycle=%0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_edge();
    bit [1:0] su, sd, refr;
    bit       busy, bu, bd;
    bit [7:0] d, st;
    int       id;
    su = '0; sd = '0; refr = '0;
    if (rst) begin
      exp_up = '0; exp_dn = '0; exp_err = 1'b0;
      m_u_up = '0; m_u_dn = '0;
      fq.delete();
      for (int p = 0; p < PLAYERS; p++) last_ref[p] = cyc;
    end else begin
      for (int p = 0; p < PLAYERS; p++) begin
        bu = !btn_clean[2*p];
        bd = !btn_clean[2*p+1];
        case (input_mode)
          2'd0:    begin su[p] = bu;              sd[p] = bd;              end
          2'd3:    begin su[p] = bu || m_u_up[p]; sd[p] = bd || m_u_dn[p]; end
          default: begin su[p] = m_u_up[p];       sd[p] = m_u_dn[p];       end
        endcase
      end
      exp_up  = su & ~sd;
      exp_dn  = sd & ~su;
      exp_err = 1'b0;
      if (input_mode != prev_mode) begin
        m_u_up = '0; m_u_dn = '0;
        fq.delete();
        for (int p = 0; p < PLAYERS; p++) last_ref[p] = cyc;
      end else begin
        busy = (fq.size() > 0) && ((cyc - last_byte) <= GAP_CYCLES);
        if (!busy) fq.delete();
        if (rx_valid) begin
          d = rx_data;
          if (input_mode >= 2'd2) begin
            if (fq.size() == 0) begin
              if (d == 8'hA5) begin fq.push_back(d); last_byte = cyc; end
            end else begin
              fq.push_back(d);
              last_byte = cyc;
              if (fq.size() == 4) begin
                id = int'(fq[1]);
                st = fq[2];
                if (id < PLAYERS && fq[3] == (fq[1] ^ fq[2])) begin
                  m_u_up[id] = st[0];
                  m_u_dn[id] = st[1];
                  refr[id]   = 1'b1;
                end else begin
                  exp_err = 1'b1;
                end
                fq.delete();
              end
            end
          end
          if (input_mode == 2'd1 || (input_mode == 2'd3 && !busy)) begin
            for (int p = 0; p < PLAYERS; p++) begin
              if (d == key_up_tab[p])           begin m_u_up[p] = 1'b1; refr[p] = 1'b1; end
              if (d == (key_up_tab[p] | 8'h20)) begin m_u_up[p] = 1'b0; refr[p] = 1'b1; end
              if (d == key_dn_tab[p])           begin m_u_dn[p] = 1'b1; refr[p] = 1'b1; end
              if (d == (key_dn_tab[p] | 8'h20)) begin m_u_dn[p] = 1'b0; refr[p] = 1'b1; end
            end
          end
        end
        for (int p = 0; p < PLAYERS; p++) begin
          if (refr[p]) last_ref[p] = cyc;
          else if ((cyc - last_ref[p]) >= TIMEOUT_CYCLES) begin
            m_u_up[p] = 1'b0;
            m_u_dn[p] = 1'b0;
          end
        end
      end
    end
    prev_mode = input_mode;
    cyc++;
  endtask

  task automatic step(input bit v, input bit [7:0] d);
    rx_valid   = v;
    rx_data    = v ? d : 8'($urandom);
    input_mode = cur_mode;
    btn_clean  = cur_btn;
    rst        = cur_rst;
    @(posedge clk);
    model_edge();
    #1;
    chk("up", {6'b0, up}, {6'b0, exp_up});
    chk("down", {6'b0, down}, {6'b0, exp_dn});
    chk("frame_err", {7'b0, frame_err}, {7'b0, exp_err});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00);
  endtask

  function automatic int pick_gap();
    int r;
    r = int'($urandom_range(0, 9));
    if (r < 6) return 0;
    if (r < 8) return 1;
    if (r == 8) return GAP_CYCLES - 1;
    return GAP_CYCLES;
  endfunction

  task automatic send_frame(input bit [7:0] id, input bit [7:0] st, input bit [7:0] ck,
                            input bit rand_gaps);
    bit [7:0] b[4];
    b[0] = 8'hA5; b[1] = id; b[2] = st; b[3] = ck;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, b[i]);
      if (rand_gaps && i < 3) idle(pick_gap());
    end
  endtask

  task automatic rand_frame();
    bit [7:0] id, st, ck;
    id = 8'($urandom_range(0, 4));
    st = 8'($urandom);
    ck = ($urandom_range(0, 3) != 0) ? (id ^ st) : 8'($urandom);
    send_frame(id, st, ck, 1'b1);
  endtask

  initial begin
    cur_rst = 1'b1; cur_mode = 2'd0; cur_btn = 4'hF;
    rst = 1'b1; input_mode = 2'd0; btn_clean = 4'hF; rx_valid = 1'b0; rx_data = 8'h00;
    idle(3);
    chk("reset_up", {6'b0, up}, 8'h00);
    chk("reset_down", {6'b0, down}, 8'h00);
    chk("reset_err", {7'b0, frame_err}, 8'h00);
    cur_rst = 1'b0;

    // Button mode
    cur_btn = 4'b1110; step(1'b0, 8'h00);
    chk("btn_up", {6'b0, up}, 8'h01);
    chk("btn_down", {6'b0, down}, 8'h00);
    cur_btn = 4'b1100; step(1'b0, 8'h00);
    chk("btn_conflict_up", {6'b0, up}, 8'h00);
    chk("btn_conflict_down", {6'b0, down}, 8'h00);
    for (int i = 0; i < 30; i++) begin cur_btn = 4'($urandom); step(1'b0, 8'h00); end
    cur_btn = 4'hF;

    // Keyboard mode
    cur_mode = 2'd1; idle(2);
    step(1'b1, 8'h49);
    chk("kbd_I_latency", {6'b0, up}, 8'h00);
    step(1'b0, 8'h00);
    chk("kbd_I_up", {6'b0, up}, 8'h02);
    step(1'b1, 8'h69);
    chk("kbd_i_latency", {6'b0, up}, 8'h02);
    step(1'b0, 8'h00);
    chk("kbd_i_up", {6'b0, up}, 8'h00);
    step(1'b1, 8'h54); idle(3);
    chk("kbd_T_ignored", {6'b0, up | down}, 8'h00);
    for (int i = 0; i < 40; i++) begin
      step(1'b1, key_pool[$urandom_range(0, 13)]);
      idle(int'($urandom_range(0, 3)));
    end

    // Controller mode
    cur_mode = 2'd2; idle(2);
    send_frame(8'h01, 8'h02, 8'h03, 1'b0);
    chk("ctrl_ok_err", {7'b0, frame_err}, 8'h00);
    step(1'b0, 8'h00);
    chk("ctrl_ok_down", {6'b0, down}, 8'h02);
    send_frame(8'h01, 8'h02, 8'h00, 1'b0);
    chk("ctrl_badchk_err", {7'b0, frame_err}, 8'h01);
    step(1'b0, 8'h00);
    chk("ctrl_badchk_down", {6'b0, down}, 8'h02);
    send_frame(8'h05, 8'h01, 8'h04, 1'b0);
    chk("ctrl_badid_err", {7'b0, frame_err}, 8'h01);
    idle(2);
    step(1'b1, 8'hA5); step(1'b1, 8'h00); idle(GAP_CYCLES + 1);
    step(1'b1, 8'h01); step(1'b1, 8'h01); idle(3);
    chk("ctrl_gap_up", {6'b0, up}, 8'h00);
    chk("ctrl_gap_down", {6'b0, down}, 8'h02);
    step(1'b1, 8'hA5); idle(GAP_CYCLES - 1); step(1'b1, 8'h00); idle(GAP_CYCLES - 1);
    step(1'b1, 8'h01); idle(GAP_CYCLES - 1); step(1'b1, 8'h01); step(1'b0, 8'h00);
    chk("ctrl_gap_edge_up", {6'b0, up}, 8'h01);
    for (int i = 0; i < 25; i++) begin
      rand_frame();
      if ($urandom_range(0, 3) == 0) step(1'b1, 8'($urandom));
      idle(int'($urandom_range(0, 2)));
    end

    // Hold timeout
    cur_mode = 2'd1; idle(3);
    step(1'b1, 8'h57);
    idle(TIMEOUT_CYCLES);
    chk("tmo_still_high", {7'b0, up[0]}, 8'h01);
    step(1'b0, 8'h00);
    chk("tmo_expired", {7'b0, up[0]}, 8'h00);
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 8'h57);
      idle(49);
      chk("tmo_refreshed", {7'b0, up[0]}, 8'h01);
    end

    // Mode change clears UART state
    cur_mode = 2'd2; idle(2);
    chk("mode_change_up", {6'b0, up}, 8'h00);

    // Merged mode
    cur_mode = 2'd3; idle(2);
    for (int i = 0; i < 60; i++) begin
      cur_btn = 4'($urandom);
      case ($urandom_range(0, 2))
        0:       step(1'b1, key_pool[$urandom_range(0, 13)]);
        1:       rand_frame();
        default: idle(int'($urandom_range(1, 4)));
      endcase
    end
    cur_btn = 4'hF;

    // Reset mid-frame
    cur_mode = 2'd2; idle(2);
    step(1'b1, 8'hA5); step(1'b1, 8'h00);
    cur_rst = 1'b1; step(1'b0, 8'h00); cur_rst = 1'b0;
    send_frame(8'h00, 8'h01, 8'h01, 1'b0);
    step(1'b0, 8'h00);
    chk("rst_midframe_up", {6'b0, up}, 8'h01);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
